// File: rtl/parking_pkg.sv
// Shared types and sensor codes for the parking gate decoder.
package parking_pkg;

   // Car-tracking states: EN_* walk an entry (A then B), EX_* walk an exit (B then A).
   typedef enum logic [2:0] {
      IDLE,
      EN_A,
      EN_AB,
      EN_B,
      EX_B,
      EX_AB,
      EX_A,
      ERR
   } gate_state_t;

   // Debounced sensor pair encoded as {a, b}.
   localparam logic [1:0] S_NONE = 2'b00;
   localparam logic [1:0] S_A    = 2'b10;
   localparam logic [1:0] S_AB   = 2'b11;
   localparam logic [1:0] S_B    = 2'b01;

endpackage

// File: rtl/parking_gate_decoder_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer for one sensor.
module sensor_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic clean
);
   import parking_pkg::*;

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // The output flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_meta_reg;
   logic             sync_reg;
   logic [CNT_W-1:0] count_reg;
   logic             clean_reg;

   // Synchronize the raw input, then count cycles of disagreement before flipping.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta_reg <= 1'b0;
         sync_reg      <= 1'b0;
         count_reg     <= '0;
         clean_reg     <= 1'b0;
      end else begin
         sync_meta_reg <= raw;
         sync_reg      <= sync_meta_reg;
         if (sync_reg != clean_reg) begin
            if (count_reg == CNT_LAST) begin
               clean_reg <= sync_reg;
               count_reg <= '0;
            end else begin
               count_reg <= count_reg + CNT_W'(1);
            end
         end else begin
            count_reg <= '0;
         end
      end
   end

   assign clean = clean_reg;

endmodule

// File: rtl/parking_gate_decoder.sv
// Turns the outer (A) and inner (B) gate sensors into enter/exit pulses by
// following the car through the ordered blocking pattern of both beams.
module parking_gate_decoder #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic a_raw,
   input  logic b_raw,
   output logic enter,
   output logic exit,
   output logic busy,
   output logic seq_err
);
   import parking_pkg::*;

   logic        a_db;
   logic        b_db;
   logic [1:0]  s;

   gate_state_t state_reg, state_next;
   logic        enter_reg, enter_next;
   logic        exit_reg, exit_next;
   logic        seq_err_reg, seq_err_next;
   logic        busy_reg;

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
      .clk   (clk),
      .reset (reset),
      .raw   (a_raw),
      .clean (a_db)
   );

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
      .clk   (clk),
      .reset (reset),
      .raw   (b_raw),
      .clean (b_db)
   );

   assign s = {a_db, b_db};

   // State register; pulses and busy are registered alongside the transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         enter_reg   <= 1'b0;
         exit_reg    <= 1'b0;
         seq_err_reg <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         enter_reg   <= enter_next;
         exit_reg    <= exit_next;
         seq_err_reg <= seq_err_next;
         busy_reg    <= (state_next != IDLE);
      end
   end

   // Next-state decode; a pulse is raised only on the transition that earns it.
   always_comb begin
      state_next   = state_reg;
      enter_next   = 1'b0;
      exit_next    = 1'b0;
      seq_err_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (s == S_A)       state_next = EN_A;
            else if (s == S_B)  state_next = EX_B;
            else if (s == S_AB) begin state_next = ERR; seq_err_next = 1'b1; end
         end
         EN_A: begin
            if (s == S_AB)        state_next = EN_AB;
            else if (s == S_NONE) state_next = IDLE;
            else if (s == S_B)    begin state_next = ERR; seq_err_next = 1'b1; end
         end
         EN_AB: begin
            if (s == S_B)         state_next = EN_B;
            else if (s == S_A)    state_next = EN_A;
            else if (s == S_NONE) begin state_next = ERR; seq_err_next = 1'b1; end
         end
         EN_B: begin
            if (s == S_NONE)      begin state_next = IDLE; enter_next = 1'b1; end
            else if (s == S_AB)   state_next = EN_AB;
            else if (s == S_A)    begin state_next = ERR; seq_err_next = 1'b1; end
         end
         EX_B: begin
            if (s == S_AB)        state_next = EX_AB;
            else if (s == S_NONE) state_next = IDLE;
            else if (s == S_A)    begin state_next = ERR; seq_err_next = 1'b1; end
         end
         EX_AB: begin
            if (s == S_A)         state_next = EX_A;
            else if (s == S_B)    state_next = EX_B;
            else if (s == S_NONE) begin state_next = ERR; seq_err_next = 1'b1; end
         end
         EX_A: begin
            if (s == S_NONE)      begin state_next = IDLE; exit_next = 1'b1; end
            else if (s == S_AB)   state_next = EX_AB;
            else if (s == S_B)    begin state_next = ERR; seq_err_next = 1'b1; end
         end
         ERR: begin
            if (s == S_NONE)      state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign enter   = enter_reg;
   assign exit    = exit_reg;
   assign seq_err = seq_err_reg;
   assign busy    = busy_reg;

endmodule

// File: tb/tb_parking_gate_decoder.sv
// Directed bench for parking_gate_decoder with DEBOUNCE_CYCLES = 4.
module tb_parking_gate_decoder;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic a_raw = 1'b0;
   logic b_raw = 1'b0;
   logic enter, exit, busy, seq_err;

   int checks = 0;
   int errors = 0;
   int enter_cnt = 0;
   int exit_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   bit busy_seen = 1'b0;

   parking_gate_decoder #(.DEBOUNCE_CYCLES(4)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .a_raw   (a_raw),
      .b_raw   (b_raw),
      .enter   (enter),
      .exit    (exit),
      .busy    (busy),
      .seq_err (seq_err)
   );

   always #5 clk = ~clk;

   // Pulse/busy bookkeeping sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (enter) enter_cnt++;
         if (exit) exit_cnt++;
         if (seq_err) err_cnt++;
         if (enter && exit) both_cnt++;
         if (busy) busy_seen = 1'b1;
      end
   end

   task automatic check_value(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Called at a negedge: apply the code and stay for n cycles, ending on a negedge.
   task automatic hold(input logic a, input logic b, input int n);
      a_raw = a;
      b_raw = b;
      repeat (n) @(negedge clk);
   endtask

   // Count posedges until enter rises; 0 means it never did within the bound.
   task automatic wait_enter(output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (enter) begin
            n = i;
            break;
         end
      end
   endtask

   int e0, x0, r0, lat;

   initial begin
      // 1: reset with A blocked
      a_raw = 1'b1;
      repeat (3) @(negedge clk);
      check_value("rst_enter", int'(enter), 0);
      check_value("rst_exit", int'(exit), 0);
      check_value("rst_seq_err", int'(seq_err), 0);
      check_value("rst_busy", int'(busy), 0);
      reset = 1'b0;
      @(negedge clk);
      check_value("post_rst_idle", int'(busy), 0);
      repeat (10) @(negedge clk);
      check_value("post_rst_en_a", int'(busy), 1);
      hold(0, 0, 10);
      check_value("post_rst_abort_busy", int'(busy), 0);
      check_value("post_rst_no_enter", enter_cnt, 0);

      // 2: full entry with latency
      e0 = enter_cnt; x0 = exit_cnt;
      hold(1, 0, 10);
      check_value("entry_busy_en_a", int'(busy), 1);
      hold(1, 1, 10);
      hold(0, 1, 10);
      check_value("entry_busy_en_b", int'(busy), 1);
      check_value("entry_no_early", enter_cnt - e0, 0);
      a_raw = 1'b0; b_raw = 1'b0;
      wait_enter(lat);
      check_value("entry_latency", lat, 7);
      @(negedge clk);
      check_value("entry_busy_after", int'(busy), 0);
      hold(0, 0, 10);
      check_value("entry_enter_cnt", enter_cnt - e0, 1);
      check_value("entry_exit_cnt", exit_cnt - x0, 0);

      // 3: exit once, then 30 back-to-back
      e0 = enter_cnt; x0 = exit_cnt;
      hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
      check_value("exit_once", exit_cnt - x0, 1);
      check_value("exit_once_enter", enter_cnt - e0, 0);
      x0 = exit_cnt;
      for (int i = 0; i < 30; i++) begin
         hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
      end
      check_value("exit_x30", exit_cnt - x0, 30);
      check_value("exit_x30_enter", enter_cnt - e0, 0);

      // 4: abort, then entry with backup
      e0 = enter_cnt; x0 = exit_cnt;
      hold(1, 0, 10);
      check_value("abort_busy_mid", int'(busy), 1);
      hold(0, 0, 10);
      check_value("abort_busy", int'(busy), 0);
      check_value("abort_no_pulse", (enter_cnt - e0) + (exit_cnt - x0), 0);
      hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(1, 1, 10);
      hold(0, 1, 10); hold(0, 0, 10);
      check_value("backup_enter", enter_cnt - e0, 1);
      check_value("backup_exit", exit_cnt - x0, 0);

      // 5: glitch of 3 cycles on A is swallowed
      e0 = enter_cnt; x0 = exit_cnt; r0 = err_cnt;
      @(posedge clk);
      busy_seen = 1'b0;
      @(negedge clk);
      hold(1, 0, 3);
      hold(0, 0, 12);
      check_value("glitch_busy", int'(busy_seen), 0);
      check_value("glitch_pulses", (enter_cnt - e0) + (exit_cnt - x0) + (err_cnt - r0), 0);

      // 6: illegal simultaneous block
      e0 = enter_cnt; r0 = err_cnt;
      hold(1, 1, 20);
      check_value("illegal_seq_err", err_cnt - r0, 1);
      check_value("illegal_busy", int'(busy), 1);
      hold(0, 0, 10);
      check_value("illegal_busy_clear", int'(busy), 0);
      check_value("illegal_no_enter", enter_cnt - e0, 0);

      // 6b: reset while in EN_AB
      e0 = enter_cnt;
      hold(1, 0, 10); hold(1, 1, 10);
      check_value("rst_mid_busy_before", int'(busy), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_value("rst_mid_busy", int'(busy), 0);
      check_value("rst_mid_enter", int'(enter), 0);
      @(negedge clk);
      a_raw = 1'b0; b_raw = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      hold(0, 0, 12);
      check_value("rst_mid_idle", int'(busy), 0);
      check_value("rst_mid_no_enter", enter_cnt - e0, 0);

      check_value("never_both", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
